// File: rtl/matrix_scan_sched.sv
// rtl/matrix_scan_sched.sv - 8x8 RGB matrix scan scheduler with per-frame collision detect
// Optional anti-ghosting blank cycle at each slot start: define SCAN_BLANKING_EN.
module matrix_scan_sched #(
    parameter int TICK_DIV = 50000
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic [7:0] player_row,
    input  logic [7:0] blue_row,
    input  logic [2:0] blue_col,
    input  logic [7:0] green_row,
    input  logic [2:0] green_col,
    input  logic       green_en,
    input  logic [1:0] mode,
    output logic [7:0] position_R,
    output logic [7:0] position_G,
    output logic [7:0] position_B,
    output logic [2:0] S,
    output logic       hit,
    output logic       frame_done
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);

    localparam logic [2:0] ST_START = 3'd0;
    localparam logic [2:0] ST_P     = 3'd1;
    localparam logic [2:0] ST_B     = 3'd2;
    localparam logic [2:0] ST_G     = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd5;
    localparam logic [2:0] ST_BLANK = 3'd6;

    // Active-high column patterns, byte n = column n
    localparam logic [63:0] WIN_PAT  = 64'h0E05050E_0F04040F;
    localparam logic [63:0] LOSE_PAT = 64'h06090906_0F04020F;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    state, state_nxt, col, col_nxt;
    logic [7:0]    pl_s, bl_s, gr_s;
    logic [2:0]    bc_s, gc_s;
    logic          gen_s, prev_c;
    logic [7:0]    pl_n, bl_n, gr_n;
    logic [2:0]    bc_n, gc_n;
    logic          last_slot, frame_start, c_now;
    logic [7:0]    r_d, g_d, b_d, pat;
    logic [2:0]    s_d;

    assign tick = (cnt == CNT_TOP);

    always_comb begin
        last_slot = 1'b0;
        case (state)
            ST_B:            last_slot = ~gen_s;
            ST_G, ST_BLANK:  last_slot = 1'b1;
            ST_WIN, ST_LOSE: last_slot = (col == 3'd7);
            default:         last_slot = 1'b0;
        endcase
    end

    assign frame_start = (state == ST_START) || (tick && last_slot);
    assign frame_done  = tick && last_slot;

    // Snapshot values that will be in force after this edge
    assign pl_n = frame_start ? player_row : pl_s;
    assign bl_n = frame_start ? blue_row   : bl_s;
    assign bc_n = frame_start ? blue_col   : bc_s;
    assign gr_n = frame_start ? green_row  : gr_s;
    assign gc_n = frame_start ? green_col  : gc_s;

    assign c_now = (mode == 2'b00) &
                   (((blue_col == 3'd0) & |(player_row & blue_row)) |
                    (green_en & (green_col == 3'd0) & |(player_row & green_row)));

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        if (frame_start) begin
            col_nxt = 3'd0;
            case (mode)
                2'b00:   state_nxt = ST_P;
                2'b01:   state_nxt = ST_WIN;
                2'b10:   state_nxt = ST_LOSE;
                default: state_nxt = ST_BLANK;
            endcase
        end else if (tick) begin
            case (state)
                ST_P:            state_nxt = ST_B;
                ST_B:            state_nxt = ST_G;
                ST_WIN, ST_LOSE: col_nxt = col + 3'd1;
                default:         state_nxt = state;
            endcase
        end
    end

    always_comb begin
        r_d = 8'hFF;
        g_d = 8'hFF;
        b_d = 8'hFF;
        s_d = 3'd0;
        pat = 8'h00;
        case (state_nxt)
            ST_P: r_d = ~pl_n;
            ST_B: begin
                b_d = ~bl_n;
                s_d = bc_n;
            end
            ST_G: begin
                g_d = ~gr_n;
                s_d = gc_n;
            end
            ST_WIN: begin
                pat = WIN_PAT[{col_nxt, 3'b000} +: 8];
                r_d = ~pat;
                g_d = ~pat;
                b_d = ~pat;
                s_d = col_nxt;
            end
            ST_LOSE: begin
                pat = LOSE_PAT[{col_nxt, 3'b000} +: 8];
                r_d = ~pat;
                if (col_nxt[2]) b_d = ~pat;
                else            g_d = ~pat;
                s_d = col_nxt;
            end
            default: s_d = 3'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            cnt        <= '0;
            state      <= ST_START;
            col        <= 3'd0;
            pl_s       <= 8'h00;
            bl_s       <= 8'h00;
            bc_s       <= 3'd0;
            gr_s       <= 8'h00;
            gc_s       <= 3'd0;
            gen_s      <= 1'b0;
            prev_c     <= 1'b0;
            hit        <= 1'b0;
            S          <= 3'd0;
            position_R <= 8'hFF;
            position_G <= 8'hFF;
            position_B <= 8'hFF;
        end else begin
            cnt   <= tick ? '0 : cnt + CW'(1);
            state <= state_nxt;
            col   <= col_nxt;
            if (frame_start) begin
                pl_s   <= player_row;
                bl_s   <= blue_row;
                bc_s   <= blue_col;
                gr_s   <= green_row;
                gc_s   <= green_col;
                gen_s  <= green_en;
                hit    <= c_now & ~prev_c;
                prev_c <= c_now;
            end else begin
                hit <= 1'b0;
            end
            S <= s_d;
`ifdef SCAN_BLANKING_EN
            if (frame_start || tick) begin
                position_R <= 8'hFF;
                position_G <= 8'hFF;
                position_B <= 8'hFF;
            end else begin
                position_R <= r_d;
                position_G <= g_d;
                position_B <= b_d;
            end
`else
            position_R <= r_d;
            position_G <= g_d;
            position_B <= b_d;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_scan_sched.sv
// tb/tb_matrix_scan_sched.sv - scoreboard bench for matrix_scan_sched
`timescale 1ns/1ps
module tb_matrix_scan_sched;

    localparam int TD = 4;

    logic       CLK = 1'b0;
    logic       Clear = 1'b0;
    logic [7:0] player_row, blue_row, green_row;
    logic [2:0] blue_col, green_col;
    logic       green_en;
    logic [1:0] mode;
    logic [7:0] position_R, position_G, position_B;
    logic [2:0] S;
    logic       hit, frame_done;

    matrix_scan_sched #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .Clear(Clear),
        .player_row(player_row), .blue_row(blue_row), .blue_col(blue_col),
        .green_row(green_row), .green_col(green_col), .green_en(green_en),
        .mode(mode),
        .position_R(position_R), .position_G(position_G), .position_B(position_B),
        .S(S), .hit(hit), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] pr, br;
        logic [2:0] bc;
        logic [7:0] gr;
        logic [2:0] gc;
        logic       ge;
    } frame_t;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic [2:0] s;
        logic       first, last, hit;
    } slot_t;

    slot_t q[$];
    int    checks = 0;
    int    failures = 0;
    bit    prev_c = 1'b0;
    logic [7:0] win_tab  [8] = '{8'h0F, 8'h04, 8'h04, 8'h0F, 8'h0E, 8'h05, 8'h05, 8'h0E};
    logic [7:0] lose_tab [8] = '{8'h0F, 8'h02, 8'h04, 8'h0F, 8'h06, 8'h09, 8'h09, 8'h06};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t mk(input logic [7:0] r, g, b, input logic [2:0] s);
        slot_t x;
        x.r = r; x.g = g; x.b = b; x.s = s;
        x.first = 1'b0; x.last = 1'b0; x.hit = 1'b0;
        return x;
    endfunction

    function automatic frame_t mkf(input logic [1:0] m, input logic [7:0] pr, br,
                                   input logic [2:0] bc, input logic [7:0] gr,
                                   input logic [2:0] gc, input logic ge);
        frame_t f;
        f.mode = m; f.pr = pr; f.br = br; f.bc = bc; f.gr = gr; f.gc = gc; f.ge = ge;
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        f.mode = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
        f.pr   = 8'd1 << $urandom_range(0, 7);
        f.br   = 8'($urandom);
        f.bc   = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom);
        f.gr   = 8'($urandom);
        f.gc   = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom);
        f.ge   = 1'($urandom);
        return f;
    endfunction

    task automatic apply(input frame_t f);
        mode = f.mode; player_row = f.pr; blue_row = f.br; blue_col = f.bc;
        green_row = f.gr; green_col = f.gc; green_en = f.ge;
    endtask

    // Reference model: list of slots for one frame plus the collision edge
    task automatic push_frame(input frame_t f, output int n);
        slot_t sl[$];
        bit c;
        case (f.mode)
            2'b00: begin
                sl.push_back(mk(~f.pr, 8'hFF, 8'hFF, 3'd0));
                sl.push_back(mk(8'hFF, 8'hFF, ~f.br, f.bc));
                if (f.ge) sl.push_back(mk(8'hFF, ~f.gr, 8'hFF, f.gc));
            end
            2'b01: for (int k = 0; k < 8; k++)
                sl.push_back(mk(~win_tab[k], ~win_tab[k], ~win_tab[k], 3'(k)));
            2'b10: for (int k = 0; k < 8; k++)
                if (k < 4) sl.push_back(mk(~lose_tab[k], ~lose_tab[k], 8'hFF, 3'(k)));
                else       sl.push_back(mk(~lose_tab[k], 8'hFF, ~lose_tab[k], 3'(k)));
            default: sl.push_back(mk(8'hFF, 8'hFF, 8'hFF, 3'd0));
        endcase
        c = (f.mode == 2'b00) &&
            ((f.bc == 3'd0 && (f.pr & f.br) != 8'h00) ||
             (f.ge && f.gc == 3'd0 && (f.pr & f.gr) != 8'h00));
        sl[0].first = 1'b1;
        sl[0].hit   = c && !prev_c;
        prev_c      = c;
        sl[sl.size()-1].last = 1'b1;
        n = sl.size();
        foreach (sl[i]) q.push_back(sl[i]);
    endtask

    // Apply f ahead of its snapshot edge, then disturb the inputs mid-frame
    task automatic run_frame(input frame_t f, input bit first);
        int n;
        #1;
        apply(f);
        push_frame(f, n);
        @(posedge CLK);
        #1;
        apply(rnd_frame());
        repeat (n * TD - (first ? 1 : 0) - 1) @(posedge CLK);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {position_R, position_G, position_B, S, hit, frame_done},
            {8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0});
    endtask

    // Monitor: pops one expected slot each time a new slot is presented
    bit    fresh = 1'b1, pend = 1'b0, have = 1'b0, pop;
    int    phase = 0;
    slot_t cur;
    logic  blank;

    initial forever begin
        @(negedge CLK);
        if (!Clear) begin
            fresh = 1'b1; pend = 1'b0; have = 1'b0; phase = 0;
        end else if (fresh) begin
            chk_reset_outputs("release_cycle");
            fresh = 1'b0; pend = 1'b1; phase = 1;
        end else begin
            pop = pend || (phase == 0);
            if (pop) begin
                pend = 1'b0;
                if (q.size() == 0) begin
                    checks++; failures++; have = 1'b0;
                    $display("FAIL queue_underflow actual=empty required=slot t=%0t", $time);
                end else begin
                    cur = q.pop_front();
                    have = 1'b1;
                end
            end
            if (have) begin
`ifdef SCAN_BLANKING_EN
                blank = pop;
`else
                blank = 1'b0;
`endif
                if (blank)
                    chk("rows_s", {position_R, position_G, position_B, S},
                        {8'hFF, 8'hFF, 8'hFF, cur.s});
                else
                    chk("rows_s", {position_R, position_G, position_B, S},
                        {cur.r, cur.g, cur.b, cur.s});
                chk("hit", {31'd0, hit}, {31'd0, pop && cur.first && cur.hit});
                chk("frame_done", {31'd0, frame_done}, {31'd0, (phase == TD - 1) && cur.last});
            end
            phase = (phase + 1) % TD;
        end
    end

    initial begin
        frame_t f0, fr;
        int n;
        f0 = mkf(2'b00, 8'h01, 8'h81, 3'd3, 8'h00, 3'd0, 1'b0);
        apply(f0);
        repeat (3) @(negedge CLK);
        chk_reset_outputs("in_reset");
        @(posedge CLK);
        #2 Clear = 1'b1;
        run_frame(f0, 1'b1);
        run_frame(f0, 1'b0);
        run_frame(mkf(2'b00, 8'h01, 8'h3C, 3'd6, 8'h03, 3'd5, 1'b1), 1'b0);
        repeat (3) run_frame(mkf(2'b00, 8'h04, 8'h0C, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b00, 8'h04, 8'h0C, 3'd3, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b00, 8'h04, 8'h0C, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b10, 8'h04, 8'h0C, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b00, 8'h04, 8'h0C, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b01, 8'h08, 8'hFF, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b11, 8'h08, 8'hFF, 3'd0, 8'h00, 3'd0, 1'b0), 1'b0);
        run_frame(mkf(2'b00, 8'h02, 8'h00, 3'd0, 8'h02, 3'd0, 1'b1), 1'b0);
        fr = rnd_frame();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) fr = rnd_frame();
            run_frame(fr, 1'b0);
        end
        // Asynchronous reset in slot 5 of a win frame
        #1;
        apply(mkf(2'b01, 8'h01, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0));
        push_frame(mkf(2'b01, 8'h01, 8'h00, 3'd0, 8'h00, 3'd0, 1'b0), n);
        @(posedge CLK);
        repeat (5 * TD) @(posedge CLK);
        #2 Clear = 1'b0;
        #1 chk_reset_outputs("async_reset");
        q.delete();
        prev_c = 1'b0;
        @(posedge CLK);
        #2 Clear = 1'b1;
        run_frame(mkf(2'b00, 8'h10, 8'h10, 3'd0, 8'h00, 3'd0, 1'b0), 1'b1);
        run_frame(mkf(2'b00, 8'h10, 8'h10, 3'd2, 8'h10, 3'd0, 1'b1), 1'b0);
        @(negedge CLK);
        #1 chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_scan_sched.md
# matrix_scan_sched

- Time-multiplexes the three game layers (player, blue wall, green wall) and the win/lose end screens onto the shared 8x8 RGB LED matrix: one column slot per scan tick.
- Detects player/wall collisions once per frame from a coherent snapshot of the layer inputs.
- Sits between the player/wall movers and the matrix pins; the HP/level logic consumes its `hit` pulse.

## Interface
- `TICK_DIV`, default 50000: CLK cycles per scan slot; legal range ≥2. Tick counter width is `$clog2(TICK_DIV)`.
- `CLK` in 1: system clock.
- `Clear` in 1: reset, asynchronous, active-low.
- `player_row` in 8: player bitmap (one-hot, bit0 = top row); the player always occupies column 0.
- `blue_row` in 8: blue wall bitmap, active-high.
- `blue_col` in 3: column of the blue wall.
- `green_row` in 8: green wall bitmap, active-high.
- `green_col` in 3: column of the green wall.
- `green_en` in 1: green layer enabled (level 2).
- `mode` in 2: 00 play, 01 win, 10 lose, 11 blank.
- `position_R`, `position_G`, `position_B` out 8 each: row drives, active-low.
- `S` out 3: selected column.
- `hit` out 1: one-cycle collision pulse.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
**Tick counter**
- Counts 0..TICK_DIV-1 and wraps.
- `tick` is asserted while count == TICK_DIV-1.
- Each slot advances on `tick`.

**Frame start**
- At the start of every frame, snapshot all layer inputs, `green_en` and `mode`.
- The frame runs entirely from the snapshot. A mode change mid-frame completes the current frame first.

**Play frame** (slot states in order)
- P_SLOT: R = ~player_row, G = B = 8'hFF, S = 0.
- B_SLOT: B = ~blue_row, R = G = 8'hFF, S = blue_col.
- G_SLOT: G = ~green_row, R = B = 8'hFF, S = green_col. Skipped entirely when snapshot `green_en` = 0, giving a 2-slot frame.

**Win frame**
- 8 slots, S = 0..7, all three colours driven identically.
- Active-high column patterns: 0F, 04, 04, 0F, 0E, 05, 05, 0E.

**Lose frame**
- 8 slots, S = 0..7.
- Columns 0-3 drive R and G with 0F, 02, 04, 0F; B = FF.
- Columns 4-7 drive R and B with 06, 09, 09, 06; G = FF.

**Blank frame**
- 1 slot; all rows FF, S = 0.

**Collision** (evaluated on the snapshot, play mode only)
- c_blue = (blue_col == 0) & |(player_row & blue_row).
- c_green = green_en & (green_col == 0) & |(player_row & green_row).
- c = c_blue | c_green.
- `hit` pulses only on a 0→1 transition of `c` between consecutive play frames. Sustained overlap produces exactly one pulse.
- Non-play frames force the stored previous `c` to 0.

**Reset**
- Asynchronous, effective immediately, including mid-frame.
- position_R/G/B = 8'hFF, S = 0, hit = 0, frame_done = 0.
- Tick count = 0, snapshot cleared, prev-c = 0.
- State returns to the frame-start of a play frame.

## Timing
- Outputs are registered and change on the CLK edge following the cycle where `tick` is high.
- First frame after reset release: the snapshot is taken on the first CLK edge, and P_SLOT outputs appear on that same edge.
- `hit` is asserted for the single cycle after the snapshot edge.
- `frame_done` is asserted for the single cycle in which the last slot of a frame ends, coincident with `tick`.
- Frame length in CLK cycles:
  - play: 3·TICK_DIV (2·TICK_DIV without green)
  - win/lose: 8·TICK_DIV
  - blank: TICK_DIV
- Simultaneous collision and mode change: the collision is evaluated against the snapshot mode. A frame snapshotted as play still reports `hit`.
- `blue_col`/`green_col` outside the visible range do not exist (3-bit); col 0 is the only collision column.

## Configuration
- `SCAN_BLANKING_EN`, defined (anti-ghosting):
  - During the first CLK cycle of every slot, all three row buses are forced to 8'hFF while S already carries the new column.
  - All other slot cycles are unchanged; frame lengths are unchanged.
- Not defined: rows and S switch on the same edge, with no blank cycle.

## Test plan
All scenarios use TICK_DIV = 4.
- **Reset/first frame.** Clear low, then high, with mode = 00, player_row = 01, green_en = 0. Required:
  - During reset: rows = FF, S = 0.
  - Slot sequence R = FE/S = 0, then B = ~blue_row/S = blue_col, repeating.
  - frame_done every 8 cycles.
- **Green layer.** green_en = 1, green_col = 5, green_row = 03. Required: the third slot shows G = FC, S = 5, and the frame is 12 cycles.
- **Collision edge.** player_row = 04, blue_col = 0, blue_row = 0C held for 3 frames. Required: exactly one `hit` pulse after the first snapshot. Then move blue_col to 3 for one frame and back to 0; required: a second pulse.
- **Mode change mid-frame.** Switch mode 00→10 during B_SLOT. Required: the play frame completes, then the lose frame runs: col0 R = G = F0, B = FF; col4 R = B = F9, G = FF; 32 cycles; no `hit` during it.
- **Reset mid-win-frame.** Assert Clear at slot 5 of a win frame. Required: outputs go to FF/S = 0 asynchronously; after release, a play frame restarts.
- **Blanking.** With SCAN_BLANKING_EN defined, required: rows = FF on cycle 0 of each slot while S holds the new column value; the remaining 3 cycles of the slot match the non-blanked build.
